// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and sizing helpers for the SPI master
package spi_pkg;

    localparam int DEF_BITS = 20;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEAD    = 3'd1,
        SCLK_HI = 3'd2,
        SCLK_LO = 3'd3,
        DONE    = 3'd4
    } spi_state_t;

    // Bit counter must be able to hold the value BITS itself.
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK half-period divider with rise/fall strobes
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int SCLK_HALF = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_sclk,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall
);

    localparam int HALF_W = $clog2(SCLK_HALF + 1);

    logic [HALF_W-1:0] cnt_q;
    logic [HALF_W-1:0] cnt_d;

    assign o_tick = i_en && (cnt_q == HALF_W'(SCLK_HALF - 1));
    assign o_rise = o_tick && !i_sclk;
    assign o_fall = o_tick && i_sclk;

    // Held at zero while disabled so every phase starts a full half-period.
    always_comb begin
        cnt_d = cnt_q + HALF_W'(1);
        if (!i_en || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 MSB-first full-duplex SPI master, one frame per request
module spi_master
    import spi_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int SCLK_HALF = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_data,
    input  logic            i_send,
    output logic [BITS-1:0] o_data,
    output logic            o_busy,
    input  logic            i_miso,
    output logic            o_mosi,
    output logic            o_sclk,
    output logic            o_ss
);

    localparam int CNT_W = cnt_width(BITS);

    spi_state_t        state_q, state_d;
    logic              sclk_q, sclk_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic [BITS-1:0]   data_q, data_d;
    logic [BITS-1:0]   tx_q, tx_d;
    logic [BITS-1:0]   rx_q, rx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;

    logic half_tick;
    logic sclk_rise;
    logic sclk_fall;
    logic gen_en;

    assign gen_en  = (state_q == LEAD) || (state_q == SCLK_HI) || (state_q == SCLK_LO);
    assign cnt_inc = cnt_q + CNT_W'(1);

    spi_sclk_gen #(
        .SCLK_HALF(SCLK_HALF)
    ) u_sclk_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (gen_en),
        .i_sclk (sclk_q),
        .o_tick (half_tick),
        .o_rise (sclk_rise),
        .o_fall (sclk_fall)
    );

    always_comb begin
        state_d = state_q;
        sclk_d  = sclk_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        data_d  = data_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;

        // MISO is captured on the same edge that raises SCLK.
        if (sclk_rise) begin
            rx_d = {rx_q[BITS-2:0], i_miso};
        end

        case (state_q)
            IDLE: begin
                if (i_send) begin
                    tx_d    = i_data;
                    rx_d    = '0;
                    cnt_d   = '0;
                    ss_d    = 1'b0;
                    mosi_d  = i_data[BITS-1];
                    busy_d  = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (half_tick) begin
                    sclk_d  = 1'b1;
                    state_d = SCLK_HI;
                end
            end
            SCLK_HI: begin
                if (sclk_fall) begin
                    sclk_d = 1'b0;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == CNT_W'(BITS)) begin
                        state_d = DONE;
                    end else begin
                        tx_d    = {tx_q[BITS-2:0], 1'b0};
                        mosi_d  = tx_q[BITS-2];
                        state_d = SCLK_LO;
                    end
                end
            end
            SCLK_LO: begin
                if (half_tick) begin
                    sclk_d  = 1'b1;
                    state_d = SCLK_HI;
                end
            end
            DONE: begin
                ss_d    = 1'b1;
                mosi_d  = 1'b0;
                data_d  = rx_q;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_data = data_q;
    assign o_busy = busy_q;
    assign o_mosi = mosi_q;
    assign o_sclk = sclk_q;
    assign o_ss   = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic [19:0] din;
    logic [19:0] dout;
    logic        busy;
    logic        miso;
    logic        miso_drv;
    logic        loop_en;
    logic        mosi;
    logic        sclk;
    logic        ss;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : miso_drv;

    spi_master #(
        .BITS      (20),
        .SCLK_HALF (1)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (din),
        .i_send (send),
        .o_data (dout),
        .o_busy (busy),
        .i_miso (miso),
        .o_mosi (mosi),
        .o_sclk (sclk),
        .o_ss   (ss)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses i_send, then follows the frame until o_busy drops, recording
    // busy length, SCLK rising edges and MOSI at each rising edge.
    task automatic run_frame(input logic [19:0] d, input logic [19:0] pat,
                             output int nbusy, output int nrise, output logic [19:0] mseq);
        logic prev_sclk;
        int   guard;
        nbusy     = 0;
        nrise     = 0;
        mseq      = '0;
        prev_sclk = 1'b0;
        guard     = 0;
        @(negedge clk);
        din      = d;
        send     = 1'b1;
        miso_drv = pat[19];
        @(negedge clk);
        send = 1'b0;
        din  = ~d;
        while (busy && guard < 200) begin
            nbusy++;
            if (sclk && !prev_sclk) begin
                nrise++;
                mseq = {mseq[18:0], mosi};
                if (nrise < 20) miso_drv = pat[19 - nrise];
            end
            prev_sclk = sclk;
            guard++;
            @(negedge clk);
        end
    endtask

    int          nb;
    int          nr;
    logic [19:0] ms;

    initial begin
        rst      = 1'b1;
        send     = 1'b0;
        din      = '0;
        miso_drv = 1'b0;
        loop_en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ss",   ss,   1);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_mosi", mosi, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_data", dout, 0);
        rst = 1'b0;

        loop_en = 1'b1;
        run_frame(20'hA5A5A, 20'h0, nb, nr, ms);
        check_eq("loop_busy_len", nb, 41);
        check_eq("loop_rises",    nr, 20);
        check_eq("loop_mosi",     ms, 20'hA5A5A);
        check_eq("loop_data",     dout, 20'hA5A5A);
        check_eq("loop_ss_idle",  ss, 1);

        loop_en = 1'b0;
        run_frame(20'h80001, 20'h00003, nb, nr, ms);
        check_eq("order_mosi", ms, 20'h80001);
        check_eq("order_data", dout, 20'h00003);

        run_frame(20'h3C3C3, 20'hFFFFF, nb, nr, ms);
        check_eq("ones_data", dout, 20'hFFFFF);
        check_eq("ones_mosi", ms, 20'h3C3C3);
        run_frame(20'h12345, 20'h00000, nb, nr, ms);
        check_eq("zeros_data", dout, 20'h00000);
        check_eq("zeros_mosi", ms, 20'h12345);

        // Back-to-back frames with i_send held high.
        begin
            int   frames;
            int   guard;
            logic prev_busy;
            loop_en   = 1'b1;
            frames    = 0;
            guard     = 0;
            prev_busy = 1'b0;
            @(negedge clk);
            din  = 20'd1;
            send = 1'b1;
            while (frames < 3 && guard < 400) begin
                @(negedge clk);
                guard++;
                if (prev_busy && !busy) begin
                    frames++;
                    check_eq($sformatf("b2b_data%0d", frames), dout, frames);
                    check_eq($sformatf("b2b_ss%0d", frames), ss, 1);
                    din = 20'(frames + 1);
                    if (frames == 3) send = 1'b0;
                end
                prev_busy = busy;
            end
            check_eq("b2b_frames", frames, 3);
            send = 1'b0;
        end

        // Reset in the middle of a frame.
        begin
            int   rises;
            int   guard;
            logic prev_sclk;
            loop_en   = 1'b0;
            rises     = 0;
            guard     = 0;
            prev_sclk = 1'b0;
            @(negedge clk);
            din      = 20'hFFFFF;
            miso_drv = 1'b1;
            send     = 1'b1;
            @(negedge clk);
            send = 1'b0;
            while (rises < 10 && guard < 200) begin
                if (sclk && !prev_sclk) rises++;
                prev_sclk = sclk;
                if (rises < 10) begin
                    @(negedge clk);
                    guard++;
                end
            end
            check_eq("mid_rises", rises, 10);
            rst = 1'b1;
            @(negedge clk);
            check_eq("mid_rst_ss",   ss,   1);
            check_eq("mid_rst_sclk", sclk, 0);
            check_eq("mid_rst_busy", busy, 0);
            check_eq("mid_rst_data", dout, 0);
            rst = 1'b0;
        end

        loop_en = 1'b1;
        run_frame(20'h6B1C4, 20'h0, nb, nr, ms);
        check_eq("post_busy_len", nb, 41);
        check_eq("post_rises",    nr, 20);
        check_eq("post_data",     dout, 20'h6B1C4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
